eth1cfgen1_main: RTL and testbench

Top-level FPGA block for the ETH1CFGEN1 board: an SPI mode-0 slave, oversampled in the system clock domain, that receives 64-bit frames from the MCU. The low byte of the last valid frame drives the 8 test LEDs. The previous valid frame is optionally echoed on MISO. The MCU's GPIO1 line acts as the board reset.

---
 rtl/eth1cfgen1_main.sv | 123 ++++++++++++
 tb/tb_eth1cfgen1_main.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/eth1cfgen1_main.sv
// ETH1CFGEN1 top: oversampled SPI mode-0 slave, 64-bit frames drive test LEDs.
// Define SPI_ECHO_EN to echo the previous valid frame on MISO.
module eth1cfgen1_main (
    input  logic       CLK,
    input  logic       MCU_GPIO1,
    input  logic       MCU_SPI_SCK,
    input  logic       MCU_SPI_NSS,
    input  logic       MCU_SPI_MOSI,
    output logic       MCU_SPI_MISO,
    output logic [7:0] test_LED
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [2:0]  sck_q, nss_q;
    logic [1:0]  mosi_q;
    logic        sck_rise, nss_fall, nss_rise;
    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] rx_q, rx_d;
    logic        accept;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign nss_fall = ~nss_q[1] & nss_q[2];
    assign nss_rise = nss_q[1] & ~nss_q[2];

    always_ff @(posedge CLK) begin
        if (MCU_GPIO1) begin
            sck_q   <= '0;
            nss_q   <= '0;
            mosi_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
        end else begin
            sck_q   <= {sck_q[1:0], MCU_SPI_SCK};
            nss_q   <= {nss_q[1:0], MCU_SPI_NSS};
            mosi_q  <= {mosi_q[0], MCU_SPI_MOSI};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
        end
    end

    // A sample coinciding with NSS rise is shifted in before the count check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            ACTIVE: begin
                if (sck_rise) begin
                    rx_d = {rx_q[62:0], mosi_q[1]};
                    if (cnt_q != 7'd65)
                        cnt_d = cnt_q + 7'd1;
                end
                if (nss_rise) begin
                    state_d = IDLE;
                    accept  = (cnt_d == 7'd64);
                end
            end
        endcase
    end

`ifdef SPI_ECHO_EN
    logic        sck_fall;
    logic [63:0] frame_q, frame_d;
    logic [63:0] tx_q, tx_d;
    logic        miso_q, miso_d;

    assign sck_fall = ~sck_q[1] & sck_q[2];

    always_comb begin
        frame_d = accept ? rx_d : frame_q;
        tx_d    = tx_q;
        if (state_q == IDLE && nss_fall)
            tx_d = frame_q;
        else if (state_q == ACTIVE && sck_fall)
            tx_d = {tx_q[62:0], 1'b0};
        miso_d = (state_d == ACTIVE) ? tx_d[63] : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (MCU_GPIO1) begin
            frame_q <= '0;
            tx_q    <= '0;
            miso_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            tx_q    <= tx_d;
            miso_q  <= miso_d;
        end
    end

    assign test_LED     = frame_q[7:0];
    assign MCU_SPI_MISO = miso_q;
`else
    logic [7:0] led_q, led_d;

    always_comb begin
        led_d = accept ? rx_d[7:0] : led_q;
    end

    always_ff @(posedge CLK) begin
        if (MCU_GPIO1)
            led_q <= '0;
        else
            led_q <= led_d;
    end

    assign test_LED     = led_q;
    assign MCU_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_eth1cfgen1_main.sv
// Self-checking bench for eth1cfgen1_main: scoreboard of LED and MISO values.
// Works with or without SPI_ECHO_EN.
module tb_eth1cfgen1_main;

    logic       clk = 1'b0;
    logic       gpio1, sck, nss, mosi;
    logic       miso;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  led_m;
    logic [63:0] echo_m;

    eth1cfgen1_main dut (
        .CLK          (clk),
        .MCU_GPIO1    (gpio1),
        .MCU_SPI_SCK  (sck),
        .MCU_SPI_NSS  (nss),
        .MCU_SPI_MOSI (mosi),
        .MCU_SPI_MISO (miso),
        .test_LED     (led)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_miso(input int i);
`ifdef SPI_ECHO_EN
        return (i < 64) ? echo_m[63-i] : 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic spi_bit(input logic b, input logic em, input string tag);
        logic [63:0] e;
        mosi = b;
        exp_q.push_back({63'b0, em});
        clks(4);
        e = exp_q.pop_front();
        check(tag, {63'b0, miso}, e);
        sck = 1'b1;
        clks(5);
        sck = 1'b0;
        clks(5);
    endtask

    task automatic led_check(input string tag);
        logic [63:0] e;
        clks(8);
        e = exp_q.pop_front();
        check(tag, {56'b0, led}, e);
    endtask

    task automatic send_frame(input logic [63:0] d, input int nbits,
                              input string tag);
        logic b;
        nss = 1'b0;
        clks(8);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 64) ? d[63-i] : 1'b0;
            spi_bit(b, exp_miso(i), {tag, "_miso"});
        end
        nss = 1'b1;
        if (nbits == 64) begin
            led_m  = d[7:0];
            echo_m = d;
        end
        exp_q.push_back({56'b0, led_m});
        led_check({tag, "_led"});
        check({tag, "_idle_miso"}, {63'b0, miso}, 64'd0);
        clks(4);
    endtask

    initial begin
        logic [63:0] r;
        gpio1 = 1'b1;
        sck   = 1'b0;
        nss   = 1'b1;
        mosi  = 1'b0;
        led_m  = 8'h00;
        echo_m = 64'd0;
        clks(5);
        check("rst_led", {56'b0, led}, 64'd0);
        check("rst_miso", {63'b0, miso}, 64'd0);
        gpio1 = 1'b0;
        clks(4);

        // SCK activity with NSS high must be ignored
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            sck  = 1'b1;
            clks(5);
            sck  = 1'b0;
            clks(5);
        end
        check("idle_led", {56'b0, led}, 64'd0);
        check("idle_miso", {63'b0, miso}, 64'd0);

        send_frame(64'h0123456789ABCDEF, 64, "frameA");
        send_frame(64'hFFFFFFFFFFFFFF55, 63, "short");
        send_frame(64'hFFFFFFFFFFFFFF77, 65, "over");
        send_frame(64'hFEDCBA9876543210, 64, "frameB");
        send_frame(64'hA5A5_0F0F_1234_563C, 64, "frame3C");

        // reset in the middle of a frame
        r = 64'hCAFEBABE_DEADBE99;
        nss = 1'b0;
        clks(8);
        for (int i = 0; i < 32; i++)
            spi_bit(r[63-i], exp_miso(i), "mid_miso");
        gpio1 = 1'b1;
        clks(5);
        led_m  = 8'h00;
        echo_m = 64'd0;
        exp_q.push_back({56'b0, led_m});
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("midrst_led", {56'b0, led}, e);
        end
        gpio1 = 1'b0;
        clks(4);
        for (int i = 32; i < 64; i++)
            spi_bit(r[63-i], 1'b0, "aborted_miso");
        nss = 1'b1;
        exp_q.push_back({56'b0, led_m});
        led_check("aborted_led");
        clks(4);

        send_frame(64'h1111222233334A5A, 64, "after_rst");
        send_frame(64'h0F0E0D0C0B0A0981, 64, "final");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
